// File: rtl/vend_dispenser_pkg.sv
// Shared types for the vending dispenser: FSM states, change request and fault codes.
package vend_dispenser_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StVend,
      StEject,
      StWaitCoin,
      StDone,
      StFault
   } state_e;

   typedef enum logic [1:0] {
      ChgNone = 2'b00,
      ChgRs5  = 2'b01,
      ChgRs10 = 2'b10
   } change_e;

   typedef enum logic [1:0] {
      FltNone    = 2'b00,
      FltProduct = 2'b01,
      FltCoin    = 2'b10
   } fault_e;

   // Number of 5 rs coins owed; the reserved code 11 owes nothing.
   function automatic logic [1:0] coins_for(logic [1:0] chg);
      logic [1:0] n;
      case (chg)
         ChgRs5:  n = 2'd1;
         ChgRs10: n = 2'd2;
         default: n = 2'd0;
      endcase
      return n;
   endfunction

   function automatic logic is_request(logic vend, logic [1:0] chg);
      return vend | (coins_for(chg) != 2'd0);
   endfunction

endpackage

// File: rtl/vend_dispenser_if.sv
// Request, sensor and actuator signals between the vend controller and its host/mechanics.
interface vend_dispenser_if;
   logic       vend;
   logic [1:0] change;
   logic       product_sensor;
   logic       coin_sensor;
   logic       fault_clr;
   logic       motor_on;
   logic       coin_eject;
   logic       busy;
   logic       done;
   logic       fault;
   logic [1:0] fault_code;
   logic       overrun;

   modport master (
      output vend, change, product_sensor, coin_sensor, fault_clr,
      input  motor_on, coin_eject, busy, done, fault, fault_code, overrun
   );

   modport slave (
      input  vend, change, product_sensor, coin_sensor, fault_clr,
      output motor_on, coin_eject, busy, done, fault, fault_code, overrun
   );
endinterface

// File: rtl/vend_dispenser_sync_edge.sv
// Two-flop synchronizer for an asynchronous sensor level, followed by a rising-edge pulse.
module vend_dispenser_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise
);

   logic [2:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 3'b000;
      end else begin
         sync_q <= {sync_q[1:0], din};
      end
   end

   assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/vend_dispenser.sv
// Product motor and 5 rs coin hopper sequencer with timeouts, sticky fault and overrun flag.
module vend_dispenser
   import vend_dispenser_pkg::*;
#(
   parameter int unsigned MOTOR_TIMEOUT = 1000,
   parameter int unsigned EJECT_PULSE   = 4,
   parameter int unsigned COIN_TIMEOUT  = 500
) (
   input logic             clk,
   input logic             rst_n,
   vend_dispenser_if.slave bus
);

   localparam int unsigned MtrW  = $clog2(MOTOR_TIMEOUT) + 1;
   localparam int unsigned CoinW = $clog2(COIN_TIMEOUT) + 1;
   localparam int unsigned PulW  = $clog2(EJECT_PULSE) + 1;
   localparam logic [MtrW-1:0]  MtrLast  = MtrW'(MOTOR_TIMEOUT - 1);
   localparam logic [CoinW-1:0] CoinLast = CoinW'(COIN_TIMEOUT - 1);
   localparam logic [PulW-1:0]  PulLast  = PulW'(EJECT_PULSE - 1);

   state_e           state_q, state_d;
   logic [1:0]       coins_q, coins_d, left_after;
   logic [1:0]       code_q, code_d;
   logic [MtrW-1:0]  mtr_cnt_q, mtr_cnt_d;
   logic [CoinW-1:0] coin_cnt_q, coin_cnt_d;
   logic [PulW-1:0]  pul_cnt_q, pul_cnt_d;
   logic             seen_q, seen_d;
   logic             eject_start, coin_got, req;
   logic             product_edge, coin_edge;
   logic             motor_q, eject_q, busy_q, done_q, fault_q, overrun_q;
   logic             motor_d, eject_d, busy_d, done_d, fault_d, overrun_d;

   vend_dispenser_sync_edge u_sync_product (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (bus.product_sensor),
      .rise  (product_edge)
   );

   vend_dispenser_sync_edge u_sync_coin (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (bus.coin_sensor),
      .rise  (coin_edge)
   );

   assign req = is_request(bus.vend, bus.change);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         coins_q    <= 2'd0;
         code_q     <= FltNone;
         mtr_cnt_q  <= '0;
         coin_cnt_q <= '0;
         pul_cnt_q  <= '0;
         seen_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         coins_q    <= coins_d;
         code_q     <= code_d;
         mtr_cnt_q  <= mtr_cnt_d;
         coin_cnt_q <= coin_cnt_d;
         pul_cnt_q  <= pul_cnt_d;
         seen_q     <= seen_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      coins_d     = coins_q;
      code_d      = code_q;
      eject_start = 1'b0;
      left_after  = (coin_edge && coins_q != 2'd0) ? coins_q - 2'd1 : coins_q;
      // A coin seen earlier in this pulse still counts once the pulse ends.
      coin_got    = coin_edge | seen_q;

      unique case (state_q)
         StIdle: begin
            if (req) begin
               coins_d = coins_for(bus.change);
               if (bus.vend) begin
                  state_d = StVend;
               end else begin
                  state_d     = StEject;
                  eject_start = 1'b1;
               end
            end
         end
         StVend: begin
            if (product_edge) begin
               if (coins_q != 2'd0) begin
                  state_d     = StEject;
                  eject_start = 1'b1;
               end else begin
                  state_d = StDone;
               end
            end else if (mtr_cnt_q >= MtrLast) begin
               state_d = StFault;
               code_d  = FltProduct;
            end
         end
         StEject: begin
            coins_d = left_after;
            if (pul_cnt_q >= PulLast && coin_got) begin
               state_d     = (left_after != 2'd0) ? StEject : StDone;
               eject_start = (left_after != 2'd0);
            end else if (!coin_got && coin_cnt_q >= CoinLast) begin
               state_d = StFault;
               code_d  = FltCoin;
            end else if (pul_cnt_q >= PulLast) begin
               state_d = StWaitCoin;
            end
         end
         StWaitCoin: begin
            coins_d = left_after;
            if (coin_edge) begin
               state_d     = (left_after != 2'd0) ? StEject : StDone;
               eject_start = (left_after != 2'd0);
            end else if (coin_cnt_q >= CoinLast) begin
               state_d = StFault;
               code_d  = FltCoin;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         StFault: begin
            if (bus.fault_clr) begin
               state_d = StIdle;
               code_d  = FltNone;
               coins_d = 2'd0;
            end
         end
         default: state_d = StIdle;
      endcase

      // Saturating timers; the coin timer restarts with every new eject pulse.
      mtr_cnt_d = '0;
      if (state_q == StVend && state_d == StVend) begin
         mtr_cnt_d = (&mtr_cnt_q) ? mtr_cnt_q : mtr_cnt_q + 1'b1;
      end
      coin_cnt_d = '0;
      if (!eject_start && (state_d == StEject || state_d == StWaitCoin)) begin
         coin_cnt_d = (&coin_cnt_q) ? coin_cnt_q : coin_cnt_q + 1'b1;
      end
      pul_cnt_d = '0;
      if (!eject_start && state_d == StEject) begin
         pul_cnt_d = (&pul_cnt_q) ? pul_cnt_q : pul_cnt_q + 1'b1;
      end
      seen_d = eject_start ? 1'b0 : (seen_q | (state_q == StEject && coin_edge));
   end

   always_comb begin
      motor_d   = (state_d == StVend);
      eject_d   = (state_d == StEject);
      busy_d    = (state_d != StIdle);
      done_d    = (state_d == StDone);
      fault_d   = (state_d == StFault);
      overrun_d = (state_q != StIdle) && req;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         motor_q   <= 1'b0;
         eject_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         fault_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         motor_q   <= motor_d;
         eject_q   <= eject_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         fault_q   <= fault_d;
         overrun_q <= overrun_d;
      end
   end

   assign bus.motor_on   = motor_q;
   assign bus.coin_eject = eject_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.fault      = fault_q;
   assign bus.fault_code = code_q;
   assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_vend_dispenser.sv
// Directed bench for vend_dispenser: a transaction-level model checked every cycle plus literal spot checks.
module tb_vend_dispenser;

   localparam int unsigned MotorTimeout = 1000;
   localparam int unsigned EjectPulse   = 4;
   localparam int unsigned CoinTimeout  = 500;

   logic clk;
   logic rst_n;

   vend_dispenser_if bus ();

   vend_dispenser #(
      .MOTOR_TIMEOUT (MotorTimeout),
      .EJECT_PULSE   (EjectPulse),
      .COIN_TIMEOUT  (CoinTimeout)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic       e_motor, e_eject, e_busy, e_done, e_fault, e_overrun;
   logic [1:0] e_code;
   logic [2:0] ph, ch;          // sensor levels seen at the last three edges, newest in bit 0
   logic       s_vend, s_clr, s_req, p_edge, c_edge;
   logic [1:0] s_chg;
   bit         abort;

   function automatic int coins_of(input logic [1:0] c);
      return (c == 2'b01) ? 1 : (c == 2'b10) ? 2 : 0;
   endfunction

   task automatic clear_model();
      {e_motor, e_eject, e_busy, e_done, e_fault, e_overrun} = '0;
      e_code = 2'b00;
      ph     = 3'b000;
      ch     = 3'b000;
   endtask

   // Advance one clock edge and record what the controller sees at that edge.
   task automatic step(input bit busy_before);
      @(posedge clk);
      abort = !rst_n;
      if (abort) return;
      s_vend    = bus.vend;
      s_chg     = bus.change;
      s_clr     = bus.fault_clr;
      s_req     = s_vend || coins_of(s_chg) != 0;
      p_edge    = ph[1] & ~ph[2];
      c_edge    = ch[1] & ~ch[2];
      ph        = {ph[1:0], bus.product_sensor};
      ch        = {ch[1:0], bus.coin_sensor};
      e_overrun = busy_before && s_req;
   endtask

   task automatic hold_fault(input logic [1:0] code);
      e_motor = 1'b0;
      e_eject = 1'b0;
      e_fault = 1'b1;
      e_code  = code;
      forever begin
         step(1'b1);
         if (abort) return;
         if (s_clr) begin
            e_fault = 1'b0;
            e_code  = 2'b00;
            e_busy  = 1'b0;
            return;
         end
      end
   endtask

   task automatic run_request(input bit with_vend, input int coins_in);
      int coins;
      int t;
      bit paid;
      coins  = coins_in;
      e_busy = 1'b1;
      if (with_vend) begin
         e_motor = 1'b1;
         t = 0;
         forever begin
            step(1'b1);
            if (abort) return;
            if (p_edge) break;
            t++;
            if (t == MotorTimeout) begin
               hold_fault(2'b01);
               return;
            end
         end
         e_motor = 1'b0;
      end
      while (coins > 0) begin
         e_eject = 1'b1;
         t       = 0;
         paid    = 1'b0;
         forever begin
            step(1'b1);
            if (abort) return;
            t++;
            if (c_edge) begin
               paid = 1'b1;
               if (coins > 0) coins--;
            end
            if (t >= EjectPulse && paid) break;
            if (!paid && t >= CoinTimeout) begin
               hold_fault(2'b10);
               return;
            end
            if (t >= EjectPulse) e_eject = 1'b0;
         end
      end
      e_eject = 1'b0;
      e_done  = 1'b1;
      step(1'b1);
      if (abort) return;
      e_done = 1'b0;
      e_busy = 1'b0;
   endtask

   initial begin
      forever begin
         clear_model();
         wait (rst_n === 1'b1);
         forever begin
            step(1'b0);
            if (abort) break;
            if (s_req) begin
               run_request(s_vend, coins_of(s_chg));
               if (abort) break;
            end
         end
      end
   end

   // ---------------- per-cycle comparison ----------------
   function automatic logic [7:0] dut_vec();
      return {bus.motor_on, bus.coin_eject, bus.busy, bus.done, bus.fault, bus.fault_code,
              bus.overrun};
   endfunction

   always @(negedge clk) begin
      if (!rst_n) chk("reset_outputs", dut_vec(), 8'h00);
      else chk("model", dut_vec(), {e_motor, e_eject, e_busy, e_done, e_fault, e_code, e_overrun});
   end

   // ---------------- directed stimulus ----------------
   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int  eject_cycles, eject_rises, done_cnt;
   logic prev_eject;

   initial begin
      bus.vend = 1'b0;
      bus.change = 2'b00;
      bus.product_sensor = 1'b0;
      bus.coin_sensor = 1'b0;
      bus.fault_clr = 1'b0;
      rst_n = 1'b0;
      tick(2);
      chk("reset_state", dut_vec(), 8'h00);
      #2 rst_n = 1'b1;
      tick(2);

      // Vend only, product drops 10 cycles in.
      bus.vend = 1'b1;
      tick();
      bus.vend = 1'b0;
      chk("t1_motor_on", {bus.motor_on, bus.busy}, 2'b11);
      tick(10);
      bus.product_sensor = 1'b1;
      tick(2);
      chk("t1_motor_waiting", {bus.motor_on, bus.done}, 2'b10);
      tick();
      chk("t1_done", {bus.done, bus.motor_on, bus.coin_eject, bus.busy}, 4'b1001);
      bus.product_sensor = 1'b0;
      tick();
      chk("t1_idle", {bus.busy, bus.done}, 2'b00);
      tick(4);

      // Vend with 10 rs change: two coins paid while waiting.
      bus.vend = 1'b1;
      bus.change = 2'b10;
      tick();
      bus.vend = 1'b0;
      bus.change = 2'b00;
      eject_cycles = 0;
      eject_rises = 0;
      done_cnt = 0;
      prev_eject = 1'b0;
      for (int k = 0; k <= 21; k++) begin
         if (bus.coin_eject) eject_cycles++;
         if (bus.coin_eject && !prev_eject) eject_rises++;
         prev_eject = bus.coin_eject;
         if (bus.done) done_cnt++;
         if (k == 19) chk("t2_busy_at_done", bus.busy, 1);
         if (k == 20) chk("t2_busy_fall", bus.busy, 0);
         bus.product_sensor = (k == 1);
         bus.coin_sensor = (k == 8 || k == 16);
         tick();
      end
      chk("t2_eject_cycles", 8'(eject_cycles), 8'd8);
      chk("t2_eject_pulses", 8'(eject_rises), 8'd2);
      chk("t2_done_count", 8'(done_cnt), 8'd1);
      tick(4);

      // Change only, hopper never delivers.
      bus.change = 2'b01;
      tick();
      bus.change = 2'b00;
      chk("t3_eject_start", {bus.coin_eject, bus.motor_on}, 2'b10);
      tick(499);
      chk("t3_before_timeout", {bus.fault, bus.coin_eject, bus.busy}, 3'b001);
      tick();
      chk("t3_fault", {bus.fault, bus.fault_code, bus.busy}, 4'b1101);
      tick(2);
      bus.fault_clr = 1'b1;
      tick();
      bus.fault_clr = 1'b0;
      chk("t3_cleared", {bus.busy, bus.fault, bus.fault_code}, 4'b0000);
      tick(3);

      // Product never drops.
      bus.vend = 1'b1;
      tick();
      bus.vend = 1'b0;
      tick(999);
      chk("t4_motor_before", {bus.motor_on, bus.fault}, 2'b10);
      tick();
      chk("t4_fault", {bus.motor_on, bus.fault, bus.fault_code}, 4'b0101);
      bus.vend = 1'b1;
      tick();
      bus.vend = 1'b0;
      chk("t4_overrun_in_fault", {bus.overrun, bus.fault}, 2'b11);
      tick();
      bus.fault_clr = 1'b1;
      tick();
      bus.fault_clr = 1'b0;
      chk("t4_cleared", {bus.busy, bus.fault, bus.fault_code}, 4'b0000);
      tick(3);

      // Request while busy flags overrun and is otherwise ignored.
      bus.vend = 1'b1;
      tick();
      bus.vend = 1'b0;
      tick(2);
      bus.vend = 1'b1;
      bus.change = 2'b10;
      tick();
      bus.vend = 1'b0;
      bus.change = 2'b00;
      chk("t5_overrun", bus.overrun, 1);
      bus.product_sensor = 1'b1;
      tick();
      chk("t5_overrun_one_cycle", bus.overrun, 0);
      bus.product_sensor = 1'b0;
      tick(2);
      chk("t5_done_no_coin", {bus.done, bus.coin_eject}, 2'b10);
      tick();
      bus.change = 2'b11;
      tick();
      chk("t5_reserved_ignored", {bus.busy, bus.overrun, bus.coin_eject}, 3'b000);
      tick(2);
      bus.change = 2'b00;
      chk("t5_still_idle", bus.busy, 0);
      tick(2);

      // Reset in the middle of a coin pulse.
      bus.change = 2'b10;
      tick();
      bus.change = 2'b00;
      tick(2);
      chk("t6_ejecting", bus.coin_eject, 1);
      #2 rst_n = 1'b0;
      #1 chk("t6_reset_async", {bus.coin_eject, bus.busy, bus.done}, 3'b000);
      tick(2);
      #2 rst_n = 1'b1;
      tick(6);
      chk("t6_idle_after", {bus.busy, bus.done, bus.coin_eject}, 3'b000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: run exceeded time limit, checks=%0d failures=%0d", checks,
               failures + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
